// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: decode, ID/EX..MEM/WB control regs,
// hazard detection, forwarding selects and event counters.
module ctrl_pipe_unit #(
  parameter int   REG_AW = 5,
  parameter logic FWD_EN = 1'b1,
  parameter int   CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_id,
  input  logic              valid_id,
  input  logic              redirect_ex,
  output logic              stall,
  output logic              flush_ifid,
  output logic              illegal_id,
  output logic [1:0]        ex_aluop,
  output logic              ex_alusrc,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_regwrite,
  output logic [1:0]        wb_sel,
  output logic [REG_AW-1:0] wb_rd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic              valid;
    logic [1:0]        aluop;
    logic              alusrc;
    logic              branch;
    logic              jump;
    logic              memread;
    logic              memwrite;
    logic              regwrite;
    logic [1:0]        wb_sel;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } id_ex_t;

  typedef struct packed {
    logic              valid;
    logic              memread;
    logic              memwrite;
    logic              regwrite;
    logic [1:0]        wb_sel;
    logic [REG_AW-1:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [1:0]        wb_sel;
    logic [REG_AW-1:0] rd;
  } mem_wb_t;

  id_ex_t  idex;
  ex_mem_t exmem;
  mem_wb_t memwb;
  id_ex_t  dec;

  logic [6:0]        op;
  logic [REG_AW-1:0] f_rd;
  logic [REG_AW-1:0] f_rs1;
  logic [REG_AW-1:0] f_rs2;
  logic              use1;
  logic              use2;
  logic              known;

  assign op    = instr_id[6:0];
  assign f_rd  = instr_id[7 +: REG_AW];
  assign f_rs1 = instr_id[15 +: REG_AW];
  assign f_rs2 = instr_id[20 +: REG_AW];

  always_comb begin
    dec   = '0;
    use1  = 1'b0;
    use2  = 1'b0;
    known = 1'b1;
    unique case (1'b1)
      (op == 7'b0110011): begin
        dec.aluop    = 2'b10;
        dec.regwrite = 1'b1;
        use1         = 1'b1;
        use2         = 1'b1;
      end
      (op == 7'b0010011): begin
        dec.aluop    = 2'b11;
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        use1         = 1'b1;
      end
      (op == 7'b0000011): begin
        dec.alusrc   = 1'b1;
        dec.wb_sel   = 2'b01;
        dec.regwrite = 1'b1;
        dec.memread  = 1'b1;
        use1         = 1'b1;
      end
      (op == 7'b0100011): begin
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
        use1         = 1'b1;
        use2         = 1'b1;
      end
      (op == 7'b1100011): begin
        dec.aluop  = 2'b01;
        dec.branch = 1'b1;
        use1       = 1'b1;
        use2       = 1'b1;
      end
      (op == 7'b1101111),
      (op == 7'b1100111): begin
        dec.alusrc   = 1'b1;
        dec.wb_sel   = 2'b10;
        dec.regwrite = 1'b1;
        dec.jump     = 1'b1;
        use1         = op[3] == 1'b0;
      end
      (op == 7'b0110111),
      (op == 7'b0010111): begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
      end
      default: known = 1'b0;
    endcase
    if (known && valid_id) begin
      dec.valid = 1'b1;
      dec.rd    = dec.regwrite ? f_rd : '0;
      dec.rs1   = use1 ? f_rs1 : '0;
      dec.rs2   = use2 ? f_rs2 : '0;
      if (f_rd == '0) dec.regwrite = 1'b0;
    end else begin
      dec  = '0;
      use1 = 1'b0;
      use2 = 1'b0;
    end
  end

  assign illegal_id = valid_id & ~known;

  // Only sources the ID instruction actually reads can match.
  logic hit_ex;
  logic hit_mem;
  logic load_use;
  logic raw;

  assign hit_ex = idex.valid && (idex.rd != '0) &&
                  ((use1 && idex.rd == f_rs1) ||
                   (use2 && idex.rd == f_rs2));
  assign hit_mem = exmem.valid && (exmem.rd != '0) &&
                   ((use1 && exmem.rd == f_rs1) ||
                    (use2 && exmem.rd == f_rs2));

  assign load_use = idex.memread & hit_ex;
  assign raw      = (FWD_EN == 1'b0) &&
                    ((idex.regwrite && hit_ex) ||
                     (exmem.regwrite && hit_mem));

  assign stall      = valid_id & (load_use | raw) & ~redirect_ex;
  assign flush_ifid = redirect_ex;

  function automatic logic [1:0] fsel(
    input logic [REG_AW-1:0] rs,
    input ex_mem_t           m,
    input mem_wb_t           w
  );
    logic [1:0] s;
    s = 2'b00;
    if (m.valid && m.regwrite && m.rd != '0 && m.rd == rs)
      s = 2'b10;
    else if (w.valid && w.regwrite && w.rd != '0 && w.rd == rs)
      s = 2'b01;
    return s;
  endfunction

  assign fwd_a = FWD_EN ? fsel(idex.rs1, exmem, memwb) : 2'b00;
  assign fwd_b = FWD_EN ? fsel(idex.rs2, exmem, memwb) : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex      <= '0;
      exmem     <= '0;
      memwb     <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      idex           <= (redirect_ex || stall) ? '0 : dec;
      exmem.valid    <= idex.valid;
      exmem.memread  <= idex.memread;
      exmem.memwrite <= idex.memwrite;
      exmem.regwrite <= idex.regwrite;
      exmem.wb_sel   <= idex.wb_sel;
      exmem.rd       <= idex.rd;
      memwb.valid    <= exmem.valid;
      memwb.regwrite <= exmem.regwrite;
      memwb.wb_sel   <= exmem.wb_sel;
      memwb.rd       <= exmem.rd;
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (redirect_ex && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign ex_aluop    = idex.aluop;
  assign ex_alusrc   = idex.alusrc;
  assign ex_branch   = idex.branch;
  assign ex_jump     = idex.jump;
  assign ex_rs1      = idex.rs1;
  assign ex_rs2      = idex.rs2;
  assign mem_read    = exmem.memread;
  assign mem_write   = exmem.memwrite;
  assign wb_regwrite = memwb.regwrite;
  assign wb_sel      = memwb.wb_sel;
  assign wb_rd       = memwb.rd;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit: forwarding build (a_*) and
// stall-only build with narrow counters (b_*) driven side by side.
module tb_ctrl_pipe_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        valid;
  logic        redir;

  logic        a_stall, a_flush, a_ill;
  logic [1:0]  a_aluop;
  logic        a_alusrc, a_branch, a_jump;
  logic [4:0]  a_rs1, a_rs2;
  logic [1:0]  a_fa, a_fb;
  logic        a_mr, a_mw, a_rw;
  logic [1:0]  a_wsel;
  logic [4:0]  a_wrd;
  logic [15:0] a_scnt, a_fcnt;

  logic        b_stall, b_flush, b_ill;
  logic [1:0]  b_aluop;
  logic        b_alusrc, b_branch, b_jump;
  logic [4:0]  b_rs1, b_rs2;
  logic [1:0]  b_fa, b_fb;
  logic        b_mr, b_mw, b_rw;
  logic [1:0]  b_wsel;
  logic [4:0]  b_wrd;
  logic [3:0]  b_scnt, b_fcnt;

  int total = 0;
  int bad   = 0;

  ctrl_pipe_unit #(.REG_AW(5), .FWD_EN(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .instr_id(instr), .valid_id(valid),
    .redirect_ex(redir), .stall(a_stall), .flush_ifid(a_flush),
    .illegal_id(a_ill), .ex_aluop(a_aluop), .ex_alusrc(a_alusrc),
    .ex_branch(a_branch), .ex_jump(a_jump), .ex_rs1(a_rs1),
    .ex_rs2(a_rs2), .fwd_a(a_fa), .fwd_b(a_fb), .mem_read(a_mr),
    .mem_write(a_mw), .wb_regwrite(a_rw), .wb_sel(a_wsel),
    .wb_rd(a_wrd), .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
  );

  ctrl_pipe_unit #(.REG_AW(5), .FWD_EN(1'b0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .instr_id(instr), .valid_id(valid),
    .redirect_ex(redir), .stall(b_stall), .flush_ifid(b_flush),
    .illegal_id(b_ill), .ex_aluop(b_aluop), .ex_alusrc(b_alusrc),
    .ex_branch(b_branch), .ex_jump(b_jump), .ex_rs1(b_rs1),
    .ex_rs2(b_rs2), .fwd_a(b_fa), .fwd_b(b_fb), .mem_read(b_mr),
    .mem_write(b_mw), .wb_regwrite(b_rw), .wb_sel(b_wsel),
    .wb_rd(b_wrd), .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc(
    input logic [6:0] op, input logic [4:0] rd,
    input logic [4:0] rs1, input logic [4:0] rs2
  );
    return {7'b0, rs2, rs1, 3'b000, rd, op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ADD3, SUB4, LW5, ADD6, ADD4, ILL, JAL1;

  initial begin
    ADD3 = enc(7'b0110011, 5'd3, 5'd1, 5'd2);
    SUB4 = 32'h4000_0000 | enc(7'b0110011, 5'd4, 5'd3, 5'd1);
    LW5  = enc(7'b0000011, 5'd5, 5'd1, 5'd0);
    ADD6 = enc(7'b0110011, 5'd6, 5'd5, 5'd2);
    ADD4 = enc(7'b0110011, 5'd4, 5'd3, 5'd1);
    ILL  = enc(7'b1111111, 5'd7, 5'd0, 5'd0);
    JAL1 = enc(7'b1101111, 5'd1, 5'd0, 5'd0);

    rst = 1'b1; instr = '0; valid = 1'b0; redir = 1'b0;
    #2;
    chk("rst_aluop", a_aluop, 0);
    chk("rst_wbrd", a_wrd, 0);
    chk("rst_fwd", {a_fa, a_fb}, 0);
    chk("rst_cnt", {a_scnt, a_fcnt}, 0);
    chk("rst_stall", {a_stall, a_flush, a_ill}, 0);
    cyc(); cyc();
    rst = 1'b0;

    // add x3 ; sub x4,x3,x1 : forward from MEM
    cyc(); instr = ADD3; valid = 1'b1; #1;
    chk("A_stall0", a_stall, 0);
    cyc(); instr = SUB4; #1;
    chk("A_stall1", a_stall, 0);
    chk("A_exrs1", a_rs1, 1);
    cyc(); valid = 1'b0; #1;
    chk("A_fwda", a_fa, 2'b10);
    chk("A_fwdb", a_fb, 2'b00);
    chk("A_aluop", a_aluop, 2'b10);
    cyc(); #1;
    chk("A_wbrd", a_wrd, 3);
    chk("A_wbrw", a_rw, 1);
    cyc(); cyc();

    // lw x5 ; add x6,x5,x2 : one load-use bubble then WB forward
    cyc(); instr = LW5; valid = 1'b1; #1;
    chk("B_stall0", a_stall, 0);
    cyc(); instr = ADD6; #1;
    chk("B_stall1", a_stall, 1);
    cyc(); #1;
    chk("B_stall2", a_stall, 0);
    chk("B_memrd", a_mr, 1);
    chk("B_bubble", a_aluop, 0);
    cyc(); valid = 1'b0; #1;
    chk("B_fwda", a_fa, 2'b01);
    chk("B_wbsel", a_wsel, 2'b01);
    chk("B_scnt", a_scnt, 1);
    cyc(); cyc();

    // redirect while a load-use hazard is pending
    cyc(); instr = LW5; valid = 1'b1; #1;
    cyc(); instr = ADD6; redir = 1'b1; #1;
    chk("C_flush", a_flush, 1);
    chk("C_stall", a_stall, 0);
    cyc(); redir = 1'b0; valid = 1'b0; #1;
    chk("C_exrs1", a_rs1, 0);
    chk("C_aluop", a_aluop, 0);
    chk("C_memrd", a_mr, 1);
    chk("C_fcnt", a_fcnt, 1);
    chk("C_scnt", a_scnt, 1);
    cyc();

    // asynchronous reset in the middle of a stall
    cyc(); instr = LW5; valid = 1'b1; #1;
    cyc(); instr = ADD6; #1;
    chk("E_stall", a_stall, 1);
    chk("E_alusrc", a_alusrc, 1);
    rst = 1'b1; #1;
    chk("E_stall_rst", a_stall, 0);
    chk("E_alusrc_rst", a_alusrc, 0);
    chk("E_wb_rst", {a_rw, a_wrd, a_mr}, 0);
    chk("E_cnt_rst", {a_scnt, a_fcnt}, 0);
    chk("E_bcnt_rst", {b_scnt, b_fcnt}, 0);
    #1; rst = 1'b0;
    cyc(); #1;
    chk("E_load_rs1", a_rs1, 5);
    chk("E_load_alu", a_aluop, 2'b10);
    chk("E_scnt", a_scnt, 0);
    valid = 1'b0;
    cyc(); cyc(); cyc();

    // no forwarding: distance-1 dependence stalls two cycles
    cyc(); instr = ADD3; valid = 1'b1; #1;
    chk("D_stall0", b_stall, 0);
    cyc(); instr = ADD4; #1;
    chk("D_stall1", b_stall, 1);
    chk("D_astall", a_stall, 0);
    chk("D_fwd1", {b_fa, b_fb}, 0);
    cyc(); #1;
    chk("D_stall2", b_stall, 1);
    chk("D_fwd2", {b_fa, b_fb}, 0);
    cyc(); #1;
    chk("D_stall3", b_stall, 0);
    chk("D_scnt", b_scnt, 2);
    cyc(); valid = 1'b0; #1;
    chk("D_exrs1", b_rs1, 3);
    chk("D_fwd4", {b_fa, b_fb}, 0);
    cyc(); cyc(); cyc();

    // illegal opcode followed by JAL x1
    cyc(); instr = ILL; valid = 1'b1; #1;
    chk("F_ill", a_ill, 1);
    chk("F_stall", a_stall, 0);
    cyc(); instr = JAL1; #1;
    chk("F_ill_jal", a_ill, 0);
    chk("F_ex_bub", {a_aluop, a_jump, a_alusrc}, 0);
    cyc(); valid = 1'b0; instr = ILL; #1;
    chk("F_ill_inv", a_ill, 0);
    chk("F_exjump", a_jump, 1);
    cyc(); #1;
    chk("F_wb_bub", {a_rw, a_wrd}, 0);
    cyc(); #1;
    chk("F_wbsel", a_wsel, 2'b10);
    chk("F_wbrd", a_wrd, 1);
    chk("F_wbrw", a_rw, 1);

    // 2^4+3 redirect cycles saturate the narrow flush counter
    cyc(); redir = 1'b1; #1;
    chk("G_flush", a_flush, 1);
    repeat (19) cyc();
    redir = 1'b0; #1;
    chk("G_bfcnt", b_fcnt, 4'hF);
    chk("G_afcnt", a_fcnt, 19);
    chk("G_bscnt", b_scnt, 2);
    chk("G_ascnt", a_scnt, 0);
    chk("G_flush0", a_flush, 0);
    cyc(); #1;
    chk("G_bfcnt_hold", b_fcnt, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_unit.md
# ctrl_pipe_unit

Pipelined control unit for the RV32I 5-stage core. It decodes the ID-stage opcode into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use and RAW hazards, inserts bubbles, flushes on redirect, drives forwarding selects and keeps saturating stall/flush counters. It sits between the IF/ID register and the datapath stage registers, and covers more opcodes than the combinational decoder.

## Interface
- REG_AW, 5, register-address width
- FWD_EN, 1, 1 = drive forwarding selects; 0 = fwd outputs held 00 and all RAW hazards resolved by stalling
- CNT_W, 16, width of the saturating performance counters
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- instr_id  in  32  instruction held in IF/ID
- valid_id  in  1  IF/ID holds a real instruction
- redirect_ex  in  1  taken branch or jump resolved in EX this cycle
- stall  out  1  hold PC and IF/ID (combinational)
- flush_ifid  out  1  clear IF/ID on next edge (combinational)
- illegal_id  out  1  valid_id with unknown opcode (combinational)
- ex_aluop  out  2  ALU op class in EX
- ex_alusrc, ex_branch, ex_jump  out  1 each  EX controls
- ex_rs1, ex_rs2  out  REG_AW each  EX source register addresses
- fwd_a, fwd_b  out  2 each  operand forward select: 00 regfile, 01 WB, 10 MEM
- mem_read, mem_write  out  1 each  MEM controls
- wb_regwrite  out  1  WB write enable
- wb_sel  out  2  WB source: 00 ALU, 01 memory, 10 PC+4
- wb_rd  out  REG_AW  WB destination
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- Decode from instr_id[6:0]. rd is [11:7], rs1 is [19:15], rs2 is [24:20]. Signal order: aluop, alusrc, wb_sel, regwrite, memread, memwrite, branch, jump.
  - 0110011 R: 10,0,00,1,0,0,0,0. Uses rs1 and rs2.
  - 0010011 I-ALU: 11,1,00,1,0,0,0,0. Uses rs1.
  - 0000011 load: 00,1,01,1,1,0,0,0. Uses rs1.
  - 0100011 store: 00,1,00,0,0,1,0,0. Uses rs1 and rs2.
  - 1100011 branch: 01,0,00,0,0,0,1,0. Uses rs1 and rs2.
  - 1101111 JAL: 00,1,10,1,0,0,0,1. Uses no sources.
  - 1100111 JALR: 00,1,10,1,0,0,0,1. Uses rs1.
  - 0110111 LUI and 0010111 AUIPC: 00,1,00,1,0,0,0,0. Use no sources.
  - Any other opcode: all-zero bundle (bubble), illegal_id=1.
- A bubble has every control 0, rd=0 and valid=0. regwrite with rd=0 is forced to 0 at decode.
- Stage regs per stage: valid, the control subset still needed, rd. ID/EX also holds rs1 and rs2.
- Hazard terms (all combinational):
  - Load-use: ID/EX memread=1, ID/EX rd≠0, and rd matches a source the ID instruction uses.
  - If FWD_EN=0, also a hazard: EX or MEM stage has regwrite=1, rd≠0, and rd matches a used ID source.
  - The regfile writes before it reads, so the WB stage never causes a stall.
- stall = valid_id & hazard & ~redirect_ex. On stall: IF/ID held, a bubble loads into ID/EX, EX/MEM and MEM/WB advance normally.
- redirect_ex=1 gives flush_ifid=1 and loads a bubble into ID/EX. Flush has priority over stall.
- Forwarding (FWD_EN=1), fwd_a for ex_rs1 (fwd_b identical for ex_rs2):
  - 10 if MEM regwrite, MEM rd≠0 and MEM rd==ex_rs1;
  - else 01 if WB regwrite, WB rd≠0 and WB rd==ex_rs1;
  - else 00.
- A load in MEM is never forwarded; the load-use stall guarantees a gap.
- stall_cnt increments on each cycle with stall=1; flush_cnt on each cycle with redirect_ex=1. Both saturate at all-ones.

## Timing
- Reset (asynchronous) sets all stage regs to bubble and both counters to 0. Result: every ex_/mem_/wb_ output is 0 and fwd_a/fwd_b are 00. stall, flush_ifid and illegal_id are 0 whenever valid_id=0 and redirect_ex=0.
- Reset asserted mid-stall or mid-flush clears state immediately. The first edge after deassertion loads normally.
- ID to EX outputs: 1 cycle. To MEM: 2 cycles. To WB: 3 cycles. No other latency.
- A load-use stall lasts exactly 1 cycle. With FWD_EN=0, dependence distance 1 stalls 2 cycles and distance 2 stalls 1 cycle.
- Simultaneous stall condition and redirect_ex: flush wins, and stall_cnt does not increment.
- valid_id=0: a bubble enters ID/EX, no hazard is raised, and illegal_id=0.

## Test plan
- Reset: assert rst asynchronously mid-sequence -> all outputs 0 in the same cycle; counters 0.
- Back-to-back add x3,x1,x2 then sub x4,x3,x1 (FWD_EN=1) -> no stall; fwd_a=10 in the sub's EX cycle.
- lw x5,0(x1) then add x6,x5,x2 -> stall=1 for exactly 1 cycle, then fwd_a=01 in the add's EX cycle; stall_cnt=1.
- beq in EX with redirect_ex=1 while ID holds a load-use dependent -> flush_ifid=1, stall=0, ID/EX bubble; flush_cnt=1, stall_cnt unchanged.
- FWD_EN=0: add x3 then an immediately dependent add -> stall for 2 cycles; fwd_a/fwd_b stay 00 throughout.
- Opcode 1111111 with valid_id=1 -> illegal_id=1; the bubble reaches WB with wb_regwrite=0. JAL x1 -> wb_sel=10 and wb_rd=1 three cycles later.
- Drive redirect_ex for 2^CNT_W+3 cycles -> flush_cnt stops at all-ones.
